// File: rtl/extend_scheduler_if.sv
// ============================================================================
// Module   : extend_scheduler_if
// Purpose  : Requester-side and output-side handshakes of extend_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface extend_scheduler_if #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 4,
    parameter int OUTPUT_WIDTH = 8
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           out_valid;
    logic                           out_ready;
    logic [OUTPUT_WIDTH-1:0]        data_out;
    logic [$clog2(NUM_REQ)-1:0]     out_src;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, data_out, out_src
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, data_out, out_src
    );
endinterface

`default_nettype wire

// File: rtl/extend_scheduler.sv
// ============================================================================
// Module   : extend_scheduler
// Purpose  : Round-robin shared zero/sign-extension stage with one output
//            register. Optional macro EXTEND_SIGN_EN adds per-requester
//            sign extension (port sign_mode).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module extend_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 4,
    parameter int OUTPUT_WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
`ifdef EXTEND_SIGN_EN
    input  wire logic [NUM_REQ-1:0] sign_mode,
`endif
    extend_scheduler_if.slave       bus
);

    localparam int c_src_w = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [c_src_w-1:0]      r_ptr;
    logic [c_src_w-1:0]      r_src;
    logic [OUTPUT_WIDTH-1:0] r_data;

    logic                    w_any;
    logic                    w_acc;
    logic [c_src_w-1:0]      w_grant;
    logic [c_src_w-1:0]      w_ptr_nxt;
    logic [INPUT_WIDTH-1:0]  w_word;
    logic                    w_sign;
    logic [OUTPUT_WIDTH-1:0] w_ext;
    logic [NUM_REQ-1:0]      w_ready;

    // Scan from ptr+NUM_REQ-1 down to ptr so the last hit is the first in priority order.
    always_comb begin
        w_grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[c_src_w'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_grant = c_src_w'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_any     = |bus.req_valid;
    assign w_acc     = rst_n && w_any && ((r_state == EMPTY) || bus.out_ready);
    assign w_ptr_nxt = c_src_w'((int'(w_grant) + 1) % NUM_REQ);

    always_comb begin
        w_word  = '0;
        w_sign  = 1'b0;
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == c_src_w'(i)) begin
                w_word     = bus.req_data[i*INPUT_WIDTH +: INPUT_WIDTH];
                w_ready[i] = w_acc;
`ifdef EXTEND_SIGN_EN
                w_sign     = sign_mode[i];
`endif
            end
        end
    end

    // A size cast of a signed operand replicates its MSB; equal widths pass through.
    always_comb begin
        if (w_sign) begin
            w_ext = OUTPUT_WIDTH'($signed(w_word));
        end else begin
            w_ext = OUTPUT_WIDTH'(w_word);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_acc) begin
            w_state_nxt = FULL;
        end else if ((r_state == FULL) && bus.out_ready) begin
            w_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_src  <= '0;
            r_ptr  <= '0;
        end else if (w_acc) begin
            r_data <= w_ext;
            r_src  <= w_grant;
            r_ptr  <= w_ptr_nxt;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.out_valid = (r_state == FULL);
    assign bus.data_out  = r_data;
    assign bus.out_src   = r_src;

endmodule

`default_nettype wire

// File: tb/tb_extend_scheduler.sv
// ============================================================================
// Module   : tb_extend_scheduler
// Purpose  : Directed self-checking bench for extend_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_extend_scheduler;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
`ifdef EXTEND_SIGN_EN
    logic [3:0] sign_mode;
`endif

    extend_scheduler_if #(.NUM_REQ(4), .INPUT_WIDTH(4), .OUTPUT_WIDTH(8)) bus ();

    extend_scheduler #(.NUM_REQ(4), .INPUT_WIDTH(4), .OUTPUT_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef EXTEND_SIGN_EN
        .sign_mode (sign_mode),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = 16'h0000;
        bus.out_ready = 1'b0;
        tick();
        tick();
        n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        n_vec++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h expected 00", bus.data_out); end
        n_vec++; if (bus.out_src !== 2'd0) begin n_err++; $display("FAIL reset_src: got %0d expected 0", bus.out_src); end
        bus.req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL idle_ready: got %b expected 0000", bus.req_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_single;
        bus.req_valid = 4'b0100;
        bus.req_data  = 16'h0500;
        bus.out_ready = 1'b1;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b expected 0100", bus.req_ready); end
        tick();
        n_vec++; if (bus.data_out !== 8'h05) begin n_err++; $display("FAIL single_data: got %h expected 05", bus.data_out); end
        n_vec++; if (bus.out_src !== 2'd2) begin n_err++; $display("FAIL single_src: got %0d expected 2", bus.out_src); end
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
        bus.req_valid = 4'b0000;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL single_noreq_ready: got %b expected 0000", bus.req_ready); end
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b expected 0", bus.out_valid); end
        n_vec++; if (bus.data_out !== 8'h05) begin n_err++; $display("FAIL drain_data_hold: got %h expected 05", bus.data_out); end
    endtask

    task automatic test_round_robin;
        logic [7:0] exp_d [5];
        logic [3:0] exp_r;
        exp_d = '{8'h0F, 8'h01, 8'h02, 8'h03, 8'h0F};
        do_reset();
        bus.req_valid = 4'b1111;
        bus.req_data  = 16'h321F;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_r = 4'(1 << (i % 4));
            #1;
            n_vec++; if (bus.req_ready !== exp_r) begin n_err++; $display("FAIL rr_ready[%0d]: got %b expected %b", i, bus.req_ready, exp_r); end
            tick();
            n_vec++; if (bus.out_src !== 2'(i % 4)) begin n_err++; $display("FAIL rr_src[%0d]: got %0d expected %0d", i, bus.out_src, i % 4); end
            n_vec++; if (bus.data_out !== exp_d[i]) begin n_err++; $display("FAIL rr_data[%0d]: got %h expected %h", i, bus.data_out, exp_d[i]); end
            n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b expected 1", i, bus.out_valid); end
        end
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready: got %b expected 0000", bus.req_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.data_out !== 8'h0F) begin n_err++; $display("FAIL bp_data[%0d]: got %h expected 0f", i, bus.data_out); end
            n_vec++; if (bus.out_src !== 2'd0) begin n_err++; $display("FAIL bp_src[%0d]: got %0d expected 0", i, bus.out_src); end
            n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", i, bus.req_ready); end
        end
        // Pointer must still be 1 after the stall.
        bus.out_ready = 1'b1;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_resume_ready: got %b expected 0010", bus.req_ready); end
        tick();
        n_vec++; if (bus.out_src !== 2'd1) begin n_err++; $display("FAIL bp_resume_src: got %0d expected 1", bus.out_src); end
        n_vec++; if (bus.data_out !== 8'h01) begin n_err++; $display("FAIL bp_resume_data: got %h expected 01", bus.data_out); end
        bus.req_valid = 4'b0000;
        tick();
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain_valid: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid;
        bus.req_valid = 4'b0010;
        bus.req_data  = 16'h0070;
        bus.out_ready = 1'b0;
        tick();
        n_vec++; if (bus.data_out !== 8'h07) begin n_err++; $display("FAIL mid_pre_data: got %h expected 07", bus.data_out); end
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid: got %b expected 1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid: got %b expected 0", bus.out_valid); end
        n_vec++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL mid_async_data: got %h expected 00", bus.data_out); end
        n_vec++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL mid_async_ready: got %b expected 0000", bus.req_ready); end
        @(negedge clk);
        rst_n         = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = 16'h4321;
        bus.out_ready = 1'b1;
        #1;
        n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_ready: got %b expected 0001", bus.req_ready); end
        tick();
        n_vec++; if (bus.out_src !== 2'd0) begin n_err++; $display("FAIL mid_first_src: got %0d expected 0", bus.out_src); end
        n_vec++; if (bus.data_out !== 8'h01) begin n_err++; $display("FAIL mid_first_data: got %h expected 01", bus.data_out); end
        bus.req_valid = 4'b0000;
        tick();
    endtask

`ifdef EXTEND_SIGN_EN
    task automatic test_sign;
        do_reset();
        sign_mode     = 4'b0001;
        bus.req_valid = 4'b0001;
        bus.req_data  = 16'h00FF;
        bus.out_ready = 1'b1;
        tick();
        n_vec++; if (bus.data_out !== 8'hFF) begin n_err++; $display("FAIL sign_on: got %h expected ff", bus.data_out); end
        bus.req_valid = 4'b0010;
        bus.req_data  = 16'h00F0;
        tick();
        n_vec++; if (bus.data_out !== 8'h0F) begin n_err++; $display("FAIL sign_off: got %h expected 0f", bus.data_out); end
        bus.req_valid = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
`ifdef EXTEND_SIGN_EN
        sign_mode = 4'b0000;
`endif
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
`ifdef EXTEND_SIGN_EN
        test_sign();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
